// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample ratio and divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  // Clocks per oversample tick, truncated; never below 1 so the divider always advances.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud,
                                           input int unsigned os);
    int unsigned div;
    div = clk_freq / (baud * os);
    if (div == 0) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: one-clock tick every baud_div() clocks, restartable from zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned Div  = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count; restart takes priority so the next tick is a full period away.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  // Divider counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, LSB-first data, optional parity, valid/ready output with
// framing, parity and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam logic [3:0] MidTick  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
  localparam logic       ParOdd   = (PARITY_ODD != 0);
  localparam logic       ParEn    = (PARITY_EN != 0);

  logic                 sync1_q, sync2_q, prev_q, armed_q;
  logic                 tick, start_edge;
  uart_rx_state_e       state_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_perr_q, done_q, stop_ok_q, busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, frame_err_q, overrun_q;

  // A start only counts once the line has been seen idle-high on a tick since reset.
  assign start_edge = armed_q && prev_q && !sync2_q && (state_q == StIdle);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(start_edge),
    .tick   (tick)
  );

  // Two-flop synchronizer, edge-detect history and arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (tick && sync2_q) armed_q <= 1'b1;
    end
  end

  // Frame FSM: mid-bit sampling, shift register, parity check and stop-bit capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frame_perr_q <= 1'b0;
      done_q       <= 1'b0;
      stop_ok_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q      <= StStart;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            frame_perr_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt_q == MidTick) begin
              tick_cnt_q <= '0;
              if (!sync2_q) begin
                state_q <= StData;
              end else begin
                // Glitch: back to idle without touching any output.
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (tick_cnt_q == LastTick) begin
              tick_cnt_q <= '0;
              shift_q    <= {sync2_q, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == LastBit) state_q <= ParEn ? StParity : StStop;
              else                      bit_cnt_q <= bit_cnt_q + 1'b1;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            if (tick_cnt_q == LastTick) begin
              tick_cnt_q   <= '0;
              frame_perr_q <= sync2_q ^ (^shift_q) ^ ParOdd;
              state_q      <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (tick_cnt_q == LastTick) begin
              // Return to idle at mid-stop so an early next start edge is still caught.
              tick_cnt_q <= '0;
              stop_ok_q  <= sync2_q;
              done_q     <= 1'b1;
              state_q    <= StIdle;
              busy_q     <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load, overrun/framing pulses and valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (done_q && stop_ok_q && (!valid_q || rx_ready)) begin
        data_q  <= shift_q;
        perr_q  <= frame_perr_q;
        valid_q <= 1'b1;
      end else begin
        if (valid_q && rx_ready)     valid_q     <= 1'b0;
        if (done_q && stop_ok_q)     overrun_q   <= 1'b1;
        if (done_q && !stop_ok_q)    frame_err_q <= 1'b1;
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: 8N1 instance plus an even-parity instance.
module tb_uart_rx;

  localparam int BitClk = 434;  // 50 MHz / 115200, rounded

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b0;
  logic       sel_p = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_serial_m, rx_serial_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, parity_err, frame_err, overrun_err, rx_busy;
  logic       rx_valid_p, parity_err_p, frame_err_p, overrun_err_p, rx_busy_p;

  assign rx_serial_m = sel_p ? 1'b1 : line;
  assign rx_serial_p = sel_p ? line : 1'b1;

  uart_rx #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial_m), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  uart_rx #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial_p), .rx_data(rx_data_p),
    .rx_valid(rx_valid_p), .rx_ready(rx_ready), .parity_err(parity_err_p),
    .frame_err(frame_err_p), .overrun_err(overrun_err_p), .rx_busy(rx_busy_p)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: {parity_err, data}
  logic [8:0] exp_q[$], got_q[$], exp_p_q[$], got_p_q[$];

  int n_checks = 0, n_pass = 0;
  int vh_cnt = 0, fe_cnt = 0, or_cnt = 0, brise_cnt = 0;
  int rise_cyc = 0, bfall_cyc = 0, or_cyc = 0, t_start = 0;
  logic vprev = 1'b0, bprev = 1'b0;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready)   got_q.push_back({parity_err, rx_data});
    if (rx_valid_p && rx_ready) got_p_q.push_back({parity_err_p, rx_data_p});
    if (rx_valid) vh_cnt <= vh_cnt + 1;
    if (rx_valid && !vprev) rise_cyc <= cyc;
    if (bprev && !rx_busy) bfall_cyc <= cyc;
    if (!bprev && rx_busy) brise_cnt <= brise_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun_err) begin
      or_cnt <= or_cnt + 1;
      or_cyc <= cyc;
    end
    vprev <= rx_valid;
    bprev <= rx_busy;
  end

  initial begin
    #(20ns * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic line_bit(input logic b);
    line = b;
    repeat (BitClk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                            input logic stop_bit);
    @(posedge clk);
    #1;
    t_start = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (use_par) line_bit(par_bit);
    line_bit(stop_bit);
    line = 1'b1;
  endtask

  task automatic wait_got(input bit par, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ((!par && got_q.size() > 0) || (par && got_p_q.size() > 0)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int b0;
    line  = 1'b0;  // held low through reset release: must not start a frame
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun_err, rx_busy} !== 13'h0)
      $display("FAIL reset_outputs: got %h required 0",
               {rx_valid, rx_data, parity_err, frame_err, overrun_err, rx_busy});
    else n_pass++;
    b0 = brise_cnt;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if ((brise_cnt - b0) !== 0 || rx_busy !== 1'b0)
      $display("FAIL low_at_release: busy rises %0d busy %b required 0 0", brise_cnt - b0, rx_busy);
    else n_pass++;
    line = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  task automatic test_basic;
    int v0, f0, o0;
    bit ok;
    logic [8:0] e, g;
    rx_ready = 1'b1;
    v0 = vh_cnt; f0 = fe_cnt; o0 = or_cnt;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    wait_got(1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_word: no word received, required a5");
    else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) $display("FAIL basic_word: got %h required %h", g, e);
      else n_pass++;
    end
    n_checks++;
    if ((rise_cyc - t_start) !== 4108)
      $display("FAIL basic_latency: got %0d required 4108 (3 sync + 4105)", rise_cyc - t_start);
    else n_pass++;
    n_checks++;
    if ((vh_cnt - v0) !== 1) $display("FAIL basic_valid_len: got %0d required 1", vh_cnt - v0);
    else n_pass++;
    n_checks++;
    if ((fe_cnt - f0) !== 0 || (or_cnt - o0) !== 0)
      $display("FAIL basic_no_err: got fe %0d or %0d required 0 0", fe_cnt - f0, or_cnt - o0);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = vh_cnt; f0 = fe_cnt;
    @(posedge clk);
    #1;
    t_start = cyc;
    line = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    line = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    n_checks++;
    if ((bfall_cyc - t_start) !== 219)
      $display("FAIL glitch_busy_drop: got %0d required 219", bfall_cyc - t_start);
    else n_pass++;
    n_checks++;
    if ((vh_cnt - v0) !== 0 || (fe_cnt - f0) !== 0)
      $display("FAIL glitch_no_output: got valid %0d fe %0d required 0 0", vh_cnt - v0, fe_cnt - f0);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    bit ok;
    logic [8:0] e, g;
    v0 = vh_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if ((fe_cnt - f0) !== 1) $display("FAIL frame_err_pulse: got %0d required 1", fe_cnt - f0);
    else n_pass++;
    n_checks++;
    if ((vh_cnt - v0) !== 0 || got_q.size() !== 0)
      $display("FAIL frame_err_no_valid: got %0d cycles required 0", vh_cnt - v0);
    else n_pass++;
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_got(1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL frame_err_next: no word received, required 81");
    else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) $display("FAIL frame_err_next: got %h required %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_overrun;
    int o0;
    bit ok;
    logic [8:0] e, g;
    rx_ready = 1'b0;
    o0 = or_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if ((or_cnt - o0) !== 1) $display("FAIL overrun_pulse: got %0d required 1", or_cnt - o0);
    else n_pass++;
    n_checks++;
    if ((or_cyc - t_start) !== 4108)
      $display("FAIL overrun_timing: got %0d required 4108", or_cyc - t_start);
    else n_pass++;
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11)
      $display("FAIL overrun_hold: got valid %b data %h required 1 11", rx_valid, rx_data);
    else n_pass++;
    exp_q.push_back({1'b0, 8'h11});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rx_valid !== 1'b0) $display("FAIL overrun_release: got valid %b required 0", rx_valid);
    else n_pass++;
    wait_got(1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL overrun_word: no word consumed, required 11");
    else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) $display("FAIL overrun_word: got %h required %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_parity;
    bit ok;
    logic [8:0] e, g;
    got_p_q.delete();
    sel_p = 1'b1;
    for (int i = 0; i < 2; i++) begin
      // 0x07 has odd weight: even parity needs bit 1, so bit 0 must flag an error.
      exp_p_q.push_back({(i == 0), 8'h07});
      send_frame(8'h07, 1'b1, (i != 0), 1'b1);
      wait_got(1'b1, ok);
      n_checks++;
      if (!ok) $display("FAIL parity_word%0d: no word received", i);
      else begin
        e = exp_p_q.pop_front(); g = got_p_q.pop_front();
        if (g !== e) $display("FAIL parity_word%0d: got %h required %h", i, g, e);
        else n_pass++;
      end
    end
    sel_p = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int f0, o0;
    bit ok;
    logic [8:0] e, g;
    logic [7:0] d;
    rx_ready = 1'b0;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h96)
      $display("FAIL pre_reset_word: got valid %b data %h required 1 96", rx_valid, rx_data);
    else n_pass++;
    f0 = fe_cnt; o0 = or_cnt;
    d = 8'hF0;
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(d[i]);
    line = d[4];
    repeat (BitClk / 2) @(posedge clk);
    #1;
    n_checks++;
    if (rx_busy !== 1'b1) $display("FAIL mid_frame_busy: got %b required 1", rx_busy);
    else n_pass++;
    rst_n = 1'b0;
    line  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun_err, rx_busy} !== 13'h0)
      $display("FAIL mid_reset_outputs: got %h required 0",
               {rx_valid, rx_data, parity_err, frame_err, overrun_err, rx_busy});
    else n_pass++;
    rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (60) @(posedge clk);
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      wait_got(1'b0, ok);
      n_checks++;
      if (!ok) $display("FAIL after_reset_word%0d: no word received, required 5a", i);
      else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) $display("FAIL after_reset_word%0d: got %h required %h", i, g, e);
        else n_pass++;
      end
    end
    n_checks++;
    if ((fe_cnt - f0) !== 0 || (or_cnt - o0) !== 0)
      $display("FAIL after_reset_no_err: got fe %0d or %0d required 0 0", fe_cnt - f0, or_cnt - o0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_parity();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
